// File: rtl/axis_pkt_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_stim_gen
// Brief    : AXI-Stream packet generator with incrementing payload, gaps and
//            stop/done control.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_stim_gen #(
    parameter int DSIZE = 8,
    parameter int LSIZE = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [LSIZE-1:0] pkt_len_i,
    input  logic [LSIZE-1:0] pkt_num_i,
    input  logic [7:0]       gap_len_i,
    input  logic [DSIZE-1:0] seed_i,
    output logic [DSIZE-1:0] axis_tdata_o,
    output logic             axis_tvalid_o,
    input  logic             axis_tready_i,
    output logic             axis_tlast_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LSIZE-1:0] pkt_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LSIZE-1:0] len_q,   len_d;
    logic [LSIZE-1:0] num_q,   num_d;
    logic [7:0]       gap_q,   gap_d;
    logic [7:0]       gcnt_q,  gcnt_d;
    logic [LSIZE-1:0] beat_q,  beat_d;
    logic [LSIZE-1:0] cnt_q,   cnt_d;
    logic [DSIZE-1:0] data_q,  data_d;
    logic             pend_q,  pend_d;

    logic             w_hs;
    logic             w_last_beat;
    logic             w_stop;
    logic [LSIZE-1:0] w_cnt_inc;

    assign w_hs        = (state_q == S_SEND) && axis_tready_i;
    assign w_last_beat = (beat_q == (len_q - LSIZE'(1)));
    // A stop arriving in the very cycle of a decision counts as pending.
    assign w_stop      = pend_q | stop_i;
    assign w_cnt_inc   = cnt_q + LSIZE'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d   = (pkt_len_i == '0) ? LSIZE'(1) : pkt_len_i;
                    num_d   = pkt_num_i;
                    gap_d   = gap_len_i;
                    data_d  = seed_i;
                    cnt_d   = '0;
                    beat_d  = '0;
                    pend_d  = 1'b0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                pend_d = w_stop;
                if (w_hs) begin
                    data_d = data_q + DSIZE'(1);
                    if (w_last_beat) begin
                        beat_d = '0;
                        cnt_d  = w_cnt_inc;
                        if (((num_q != '0) && (w_cnt_inc == num_q)) || w_stop) begin
                            state_d = S_FIN;
                        end else if (gap_q != 8'd0) begin
                            gcnt_d  = 8'd1;
                            state_d = S_GAP;
                        end
                    end else begin
                        beat_d = beat_q + LSIZE'(1);
                    end
                end
            end
            S_GAP: begin
                pend_d = w_stop;
                if (gcnt_q == gap_q) begin
                    state_d = w_stop ? S_FIN : S_SEND;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            S_FIN: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            len_q   <= LSIZE'(1);
            num_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output.
    assign axis_tdata_o  = data_q;
    assign axis_tvalid_o = (state_q == S_SEND);
    assign axis_tlast_o  = (state_q == S_SEND) && w_last_beat;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_FIN);
    assign pkt_cnt_o     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_stim_gen
// Brief    : Self-checking bench for axis_pkt_stim_gen against a behavioural
//            packet model, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_stim_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop, tready;
    logic [15:0] pkt_len, pkt_num;
    logic [7:0]  gap_len, seed;
    logic [7:0]  tdata;
    logic        tvalid, tlast, busy, done;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    axis_pkt_stim_gen #(.DSIZE(8), .LSIZE(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .pkt_len_i    (pkt_len),
        .pkt_num_i    (pkt_num),
        .gap_len_i    (gap_len),
        .seed_i       (seed),
        .axis_tdata_o (tdata),
        .axis_tvalid_o(tvalid),
        .axis_tready_i(tready),
        .axis_tlast_o (tlast),
        .busy_o       (busy),
        .done_o       (done),
        .pkt_cnt_o    (pkt_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: describes the run as packets of m_len beats with an
    // idle countdown between them, and a one-cycle done phase at the end.
    int m_busy = 0, m_valid = 0, m_done = 0, m_beat = 0, m_len = 1;
    int m_num = 0, m_gap = 0, m_cnt = 0, m_pend = 0, m_idle = 0, m_data = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_cnt = 0; m_data = 0;
            m_beat = 0; m_pend = 0; m_idle = 0;
        end else if (m_busy == 0) begin
            if (start) begin
                m_busy = 1; m_valid = 1; m_beat = 0; m_cnt = 0; m_pend = 0; m_idle = 0;
                m_len  = (pkt_len == 16'd0) ? 1 : int'(pkt_len);
                m_num  = int'(pkt_num);
                m_gap  = int'(gap_len);
                m_data = int'(seed);
            end
        end else if (m_done != 0) begin
            m_done = 0; m_busy = 0;
        end else begin
            if (stop) m_pend = 1;
            if (m_valid != 0) begin
                if (tready) begin
                    m_data = (m_data + 1) % 256;
                    if (m_beat == m_len - 1) begin
                        m_beat = 0;
                        m_cnt  = (m_cnt + 1) % 65536;
                        if ((m_num != 0 && m_cnt == m_num) || m_pend != 0) begin
                            m_valid = 0; m_done = 1;
                        end else if (m_gap != 0) begin
                            m_valid = 0; m_idle = m_gap;
                        end
                    end else begin
                        m_beat++;
                    end
                end
            end else begin
                m_idle--;
                if (m_idle == 0) begin
                    if (m_pend != 0) m_done = 1;
                    else m_valid = 1;
                end
            end
        end
    end

    // Compare + capture, away from the active edge.
    bit          mon_en = 0;
    bit          prev_hold = 0;
    logic [7:0]  prev_d;
    logic        prev_l;
    int          cyc = 0;
    int          done_seen = 0;
    logic [7:0]  cap_d[$];
    logic        cap_l[$];
    int          cap_t[$];

    always @(negedge clk) begin
        if (mon_en) begin
            chk("tvalid", {31'd0, tvalid}, (m_valid != 0) ? 32'd1 : 32'd0);
            chk("busy", {31'd0, busy}, (m_busy != 0) ? 32'd1 : 32'd0);
            chk("done", {31'd0, done}, (m_done != 0) ? 32'd1 : 32'd0);
            chk("pkt_cnt", {16'd0, pkt_cnt}, 32'(m_cnt));
            if (m_valid != 0) begin
                chk("tdata", {24'd0, tdata}, 32'(m_data));
                chk("tlast", {31'd0, tlast}, (m_beat == m_len - 1) ? 32'd1 : 32'd0);
            end else begin
                chk("tlast_idle", {31'd0, tlast}, 32'd0);
            end
            if (prev_hold && !rst) begin
                chk("hold_valid", {31'd0, tvalid}, 32'd1);
                chk("hold_data", {24'd0, tdata}, {24'd0, prev_d});
                chk("hold_last", {31'd0, tlast}, {31'd0, prev_l});
            end
            prev_hold = tvalid && !tready;
            prev_d    = tdata;
            prev_l    = tlast;
            if (tvalid && tready) begin
                cap_d.push_back(tdata);
                cap_l.push_back(tlast);
                cap_t.push_back(cyc);
            end
            if (done) done_seen++;
        end
        cyc++;
    end

    bit bp_en = 0;
    always @(posedge clk) begin
        if (bp_en) begin
            #1 tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_d.delete(); cap_l.delete(); cap_t.delete();
        done_seen = 0;
    endtask

    task automatic do_start(input int len, input int num, input int gap, input int sd);
        pkt_len = 16'(len); pkt_num = 16'(num); gap_len = 8'(gap); seed = 8'(sd);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget && done_seen < target; i++) tick();
        chk({name, "_done_reached"}, {31'd0, (done_seen >= target)}, 32'd1);
    endtask

    // Waits at negedges until the n-th (0-based) beat is being presented.
    task automatic wait_beat(input int n, input int budget, input string name);
        int cnt = 0;
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (tvalid && tready) begin
                if (cnt == n) hit = 1;
                else cnt++;
            end
        end
        chk({name, "_beat_reached"}, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1;
        pkt_len = '0; pkt_num = '0; gap_len = '0; seed = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_tdata", {24'd0, tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        mon_en = 1;
        tick();
        rst = 1'b0;
        tick();

        // Basic run
        clear_cap();
        do_start(4, 2, 3, 8'h10);
        wait_done(1, 200, "basic");
        chk("basic_beats", 32'(cap_d.size()), 32'd8);
        if (cap_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("basic_data", {24'd0, cap_d[i]}, 32'h10 + 32'(i));
                chk("basic_last", {31'd0, cap_l[i]}, (i % 4 == 3) ? 32'd1 : 32'd0);
            end
            chk("basic_pkt0_span", 32'(cap_t[3] - cap_t[0]), 32'd3);
            chk("basic_gap", 32'(cap_t[4] - cap_t[3]), 32'd4);
        end
        chk("basic_done_once", 32'(done_seen), 32'd1);
        chk("basic_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        repeat (2) tick();

        // Backpressure
        clear_cap();
        bp_en = 1;
        do_start(5, 4, 2, 8'h33);
        wait_done(1, 2000, "bp");
        bp_en = 0;
        tick();
        tready = 1'b1;
        chk("bp_beats", 32'(cap_d.size()), 32'd20);
        if (cap_d.size() == 20) begin
            chk("bp_last_data", {24'd0, cap_d[19]}, 32'h46);
            for (int i = 0; i < 20; i++)
                chk("bp_last", {31'd0, cap_l[i]}, (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        tick();

        // Wrap and zero length, back to back
        clear_cap();
        do_start(0, 3, 0, 8'hFE);
        wait_done(1, 100, "wrap");
        chk("wrap_beats", 32'(cap_d.size()), 32'd3);
        if (cap_d.size() == 3) begin
            chk("wrap_d0", {24'd0, cap_d[0]}, 32'hFE);
            chk("wrap_d1", {24'd0, cap_d[1]}, 32'hFF);
            chk("wrap_d2", {24'd0, cap_d[2]}, 32'h00);
            chk("wrap_lasts", {29'd0, cap_l[0], cap_l[1], cap_l[2]}, 32'd7);
            chk("wrap_b2b0", 32'(cap_t[1] - cap_t[0]), 32'd1);
            chk("wrap_b2b1", 32'(cap_t[2] - cap_t[1]), 32'd1);
        end
        tick();

        // Continuous run, stop on 3rd beat of packet 5
        clear_cap();
        do_start(8, 0, 1, 8'h00);
        wait_beat(34, 1000, "cont");
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done(1, 200, "cont");
        chk("cont_beats", 32'(cap_d.size()), 32'd40);
        if (cap_d.size() == 40) chk("cont_final_data", {24'd0, cap_d[39]}, 32'h27);
        chk("cont_pkt_cnt", {16'd0, pkt_cnt}, 32'd5);
        repeat (5) tick();
        chk("cont_no_more", 32'(cap_d.size()), 32'd40);

        // Ignored and simultaneous controls
        clear_cap();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        pkt_len = 16'd3; pkt_num = 16'd2; gap_len = 8'd1; seed = 8'h20;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (2) tick();
        pkt_len = 16'd7; pkt_num = 16'd9; gap_len = 8'd0; seed = 8'h99;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, 200, "ign");
        chk("ign_beats", 32'(cap_d.size()), 32'd6);
        if (cap_d.size() == 6) chk("ign_final_data", {24'd0, cap_d[5]}, 32'h25);
        chk("ign_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        tick();

        // Reset in the middle of a packet
        clear_cap();
        do_start(6, 1, 0, 8'h40);
        wait_beat(2, 100, "rstmid");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("rstmid_no_done", 32'(done_seen), 32'd0);
        clear_cap();
        do_start(2, 1, 0, 8'h80);
        wait_done(1, 100, "replay");
        chk("replay_beats", 32'(cap_d.size()), 32'd2);
        if (cap_d.size() == 2) chk("replay_first", {24'd0, cap_d[0]}, 32'h80);
        tick();

        // Randomized runs against the model
        for (int it = 0; it < 8; it++) begin
            int len, num, gap, sd, base;
            len = int'($urandom_range(0, 6));
            num = int'($urandom_range(0, 4));
            gap = int'($urandom_range(0, 3));
            sd  = int'($urandom_range(0, 255));
            base = done_seen;
            bp_en = 1;
            do_start(len, num, gap, sd);
            repeat ($urandom_range(1, 40)) tick();
            if (num == 0 || $urandom_range(0, 1) == 1) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            wait_done(base + 1, 3000, "rand");
            bp_en = 0;
            tick();
            tready = 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/axis_pkt_stim_gen.md
# axis_pkt_stim_gen

Single-clock AXI-Stream packet generator that sits directly upstream of the top-level datapath under test and drives its stream input from a small control interface. It emits a programmable number of fixed-length packets with an incrementing payload and a programmable inter-packet gap. It also reports progress and completion back to the bench or controller. All logic runs in the global system clock domain.

## Interface

- DSIZE, 8: tdata width in bits.
- LSIZE, 16: width of the length and count fields.

Clocking and reset: one clock; reset is synchronous and active-high.

- clock  in  1  global system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches the config and begins a run.
- stop  in  1  one-cycle pulse; ends the run after the current packet.
- pkt_len  in  LSIZE  beats per packet; 0 is treated as 1.
- pkt_num  in  LSIZE  packets per run; 0 means continuous until stop.
- gap_len  in  8  idle cycles between packets.
- seed  in  DSIZE  tdata of the first beat of the run.
- axis_tdata  out  DSIZE  payload.
- axis_tvalid  out  1  beat valid.
- axis_tready  in  1  downstream ready.
- axis_tlast  out  1  last beat of the packet.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of a run.
- pkt_cnt  out  LSIZE  packets completed in the current run; wraps modulo 2^LSIZE.

## Operation

FSM states: IDLE, SEND, GAP, FIN.

- **IDLE:** on start, latch pkt_len, pkt_num, gap_len and seed. Clear pkt_cnt and the beat counter, then go to SEND.
- **SEND:**
  - tvalid is high.
  - Beat counter advances only on a handshake (tvalid & tready).
  - tlast is high when beat counter == latched len-1.
  - On the handshake of the last beat:
    - pkt_cnt increments.
    - Go to FIN if (pkt_num != 0 and pkt_cnt+1 == pkt_num) or a stop is pending.
    - Otherwise go to GAP if gap_len != 0.
    - Otherwise stay in SEND with the beat counter cleared.
- **GAP:** tvalid low for exactly gap_len cycles, then SEND.
- **FIN:** tvalid low, done pulses for one cycle, busy drops, then IDLE.

Payload and stop handling:

- tdata starts at seed and increments by 1 on every handshake, continuing across packet boundaries. It wraps modulo 2^DSIZE (0xFF -> 0x00 for DSIZE=8).
- stop sets a sticky pending flag while busy. Packets are never truncated.
- stop during GAP goes to FIN at the end of the gap, with no further packet sent.
- stop in IDLE is ignored.

AXIS rules:

- Once tvalid is high, tvalid, tdata and tlast hold stable until a handshake.
- tvalid never drops mid-packet.

Other boundary and priority rules:

- start while busy is ignored, and config changes mid-run have no effect.
- stop and start in the same IDLE cycle: start wins and stop is discarded.
- rst has priority over everything and may be asserted mid-packet. The next cycle is IDLE with all outputs at their reset values, and no done pulse is generated.

## Timing

- Reset values: axis_tvalid=0, axis_tlast=0, axis_tdata=0, busy=0, done=0, pkt_cnt=0.
- All outputs are registered; there are no combinational paths from input to output.
- start at cycle N: busy=1 and tvalid=1 with tdata=seed at N+1.
- Last beat handshake at cycle T with gap_len=G>0: tvalid=0 for T+1..T+G, next packet's first beat valid at T+G+1.
- With G=0, the next packet's first beat is valid at T+1 (back-to-back, no bubble).
- Final handshake at cycle T: FIN at T+1 with done=1; busy=0 and IDLE at T+2.
- pkt_cnt updates in the cycle after the last-beat handshake.
- Throughput with tready held high and G=0 is one beat per cycle.

## Test plan

- **Basic run:** seed=0x10, pkt_len=4, pkt_num=2, gap_len=3, tready=1.
  - Beats 0x10..0x13 with tlast on 0x13.
  - tvalid low for 3 cycles.
  - Beats 0x14..0x17 with tlast on 0x17.
  - done pulses once; pkt_cnt ends at 2.
- **Backpressure:** pkt_len=5, tready toggled pseudo-randomly.
  - tdata/tlast are held stable while tvalid & !tready.
  - Exactly 5 handshakes per packet, with no gaps in tvalid inside a packet.
- **Wrap and edge lengths:** seed=0xFE, pkt_len=0, pkt_num=3, gap_len=0.
  - Three single-beat packets 0xFE, 0xFF, 0x00, each with tlast.
  - Back-to-back on consecutive cycles.
- **Continuous plus stop:** pkt_num=0, pkt_len=8; stop asserted on the 3rd beat of packet 5.
  - Packet 5 completes with all 8 beats.
  - done pulses at the next cycle; pkt_cnt=5; no 6th packet.
- **Ignored and simultaneous controls:**
  - start while busy: no effect on the stream.
  - stop in IDLE: no effect.
  - stop together with start in IDLE: the run starts normally.
- **Reset mid-packet:** rst asserted on beat 2 of a 6-beat packet.
  - Next cycle: tvalid=0, busy=0, pkt_cnt=0, no done pulse.
  - A following start replays from the new seed.
